mem_io_responder: RTL

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder_pkg.sv | 35 +++
 rtl/mem_io_responder_sync_fifo.sv | 46 ++++
 rtl/mem_io_responder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared constants for the memory/IO responder: IO window decode and register addresses.
package mem_io_responder_pkg;

   localparam int IO_SEL_HI = 17;
   localparam int IO_SEL_LO = 16;
   localparam logic [1:0] IO_SEL_VAL = 2'b11;

   // IO registers are matched on the low address bits only; upper CPU bits are don't-care.
   localparam int IO_OFS_W = 18;
   localparam logic [IO_OFS_W-1:0] UART_ADDR = 18'h30000;
   localparam logic [IO_OFS_W-1:0] CLK_ADDR  = 18'h30004;

   typedef enum logic [2:0] {
      IO_NONE,
      IO_UART,
      IO_CLK0,
      IO_CLK1,
      IO_CLK2,
      IO_CLK3
   } io_sel_e;

   function automatic io_sel_e io_decode(input logic [IO_OFS_W-1:0] a);
      io_sel_e s;
      case (a)
         UART_ADDR:         s = IO_UART;
         CLK_ADDR:          s = IO_CLK0;
         CLK_ADDR + 18'd1:  s = IO_CLK1;
         CLK_ADDR + 18'd2:  s = IO_CLK2;
         CLK_ADDR + 18'd3:  s = IO_CLK3;
         default:           s = IO_NONE;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/mem_io_responder_sync_fifo.sv
// Single-clock byte FIFO; pointers carry an extra wrap bit to tell full from empty.
module sync_fifo #(
   parameter int FIFO_DEPTH = 8,
   parameter int W          = 8
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
   logic [W-1:0] mem_q [FIFO_DEPTH];
   logic         do_push, do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign dout_o  = mem_q[rd_q[AW-1:0]];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign wr_d    = do_push ? wr_q + 1'b1 : wr_q;
   assign rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage needs no reset: entries are only observable between the pointers.
   always_ff @(posedge clk_in) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/mem_io_responder.sv
// CPU-facing responder: byte RAM plus memory-mapped UART FIFOs, cycle counter and stop flag.
module mem_io_responder
   import mem_io_responder_pkg::*;
#(
   parameter int RAM_AW     = 17,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] cpu_addr,
   input  logic        cpu_wr,
   input  logic [7:0]  cpu_dout,
   output logic [7:0]  cpu_din,
   output logic        rdy_out,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        stop_out
);

   localparam int RAM_SZ = 1 << RAM_AW;

   logic [7:0]  ram [RAM_SZ];
   logic [7:0]  ram_q;
   logic        sel_ram_q;
   logic [7:0]  io_rd_q, io_rd_d;
   logic [31:0] cnt_q, snap_q;
   logic        stop_q;

   logic        tx_full, tx_empty, rx_full, rx_empty;
   logic [7:0]  rx_head;
   logic        acc, is_io, ram_wr, ram_rd, io_rd;
   logic        tx_push, rx_pop, stop_set, snap_cap;
   io_sel_e     sel;
   logic        unused_addr_hi;

   assign unused_addr_hi = ^cpu_addr[31:IO_OFS_W];

   // A CPU access is taken on every edge where the tx FIFO can absorb a byte.
   assign rdy_out  = !tx_full;
   assign acc      = rdy_out;
   assign is_io    = (cpu_addr[IO_SEL_HI:IO_SEL_LO] == IO_SEL_VAL);
   assign sel      = io_decode(cpu_addr[IO_OFS_W-1:0]);

   assign ram_wr   = acc && !is_io && cpu_wr;
   assign ram_rd   = acc && !is_io && !cpu_wr;
   assign io_rd    = acc && is_io && !cpu_wr;
   assign tx_push  = acc && is_io && cpu_wr && (sel == IO_UART) && (cpu_dout != 8'h00);
   assign stop_set = acc && is_io && cpu_wr && (sel == IO_CLK0);
   assign rx_pop   = io_rd && (sel == IO_UART) && !rx_empty;
   assign snap_cap = io_rd && (sel == IO_CLK0);

   always_comb begin
      io_rd_d = 8'h00;
      case (sel)
         IO_UART: io_rd_d = rx_empty ? 8'h00 : rx_head;
         IO_CLK0: io_rd_d = cnt_q[7:0];
         IO_CLK1: io_rd_d = snap_q[15:8];
         IO_CLK2: io_rd_d = snap_q[23:16];
         IO_CLK3: io_rd_d = snap_q[31:24];
         default: io_rd_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (ram_wr) ram[cpu_addr[RAM_AW-1:0]] <= cpu_dout;
      if (ram_rd) ram_q <= ram[cpu_addr[RAM_AW-1:0]];
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         sel_ram_q <= 1'b0;
         io_rd_q   <= 8'h00;
         cnt_q     <= 32'h0;
         snap_q    <= 32'h0;
         stop_q    <= 1'b0;
      end else begin
         cnt_q <= cnt_q + 32'd1;
         if (ram_rd) sel_ram_q <= 1'b1;
         if (io_rd) begin
            sel_ram_q <= 1'b0;
            io_rd_q   <= io_rd_d;
         end
         if (snap_cap) snap_q <= cnt_q;
         if (stop_set) stop_q <= 1'b1;
      end
   end

   // sel_ram_q resets low, so cpu_din reads 0x00 out of reset without clearing RAM.
   assign cpu_din  = sel_ram_q ? ram_q : io_rd_q;
   assign tx_valid = !tx_empty;
   assign rx_ready = !rx_full;
   assign stop_out = stop_q && tx_empty;

   sync_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .push_i  (tx_push),
      .din_i   (cpu_dout),
      .pop_i   (tx_ready),
      .dout_o  (tx_data),
      .full_o  (tx_full),
      .empty_o (tx_empty)
   );

   sync_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .push_i  (rx_valid),
      .din_i   (rx_data),
      .pop_i   (rx_pop),
      .dout_o  (rx_head),
      .full_o  (rx_full),
      .empty_o (rx_empty)
   );

endmodule
